// File: rtl/shutdown_sense_scan.sv
// shutdown_sense_scan: round-robin scan of eight board shutdown-sense lines
// through a shared 8:1 analog mux. Each board's synchronized sample feeds a
// consecutive-hit filter; a board that stays asserted for FILTER_COUNT visits
// latches a sticky flag that holds until the manager drops the enable.

// Per-board filter: saturating count of consecutive asserted samples, sticky flag.
module shutdown_sense_filter #(
  parameter int FILTER_COUNT = 4,
  parameter int CW           = $clog2(FILTER_COUNT + 1)
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic sample,
  input  logic pin,
  output logic flag
);

  localparam logic [CW-1:0] FC = CW'(FILTER_COUNT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Saturate at FC so a board held asserted for a long time cannot wrap.
  assign cnt_inc = (cnt == FC) ? cnt : cnt + 1'b1;

  // Count consecutive hits on this board's visits; a miss restarts the run.
  always_ff @(posedge clk) begin
    if (!aresetn || clr) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (sample) begin
      if (pin) begin
        cnt <= cnt_inc;
        if (cnt_inc == FC) flag <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module shutdown_sense_scan #(
  parameter int SETTLE_CYCLES = 250,
  parameter int FILTER_COUNT  = 4,
  parameter int ARM_DELAY     = 25000
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       shutdown_sense_en,
  input  logic       sense_pin,
  output logic [2:0] sense_sel,
  output logic [7:0] shutdown_sense,
  output logic       sense_armed
);

  localparam int NUM_BOARDS = 8;
  localparam int CW         = $clog2(FILTER_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ARM_WAIT, SETTLE, SAMPLE} state_t;

  state_t          state, state_n;
  logic [31:0]     timer, timer_n;
  logic [2:0]      sel_n;
  logic [1:0]      sync_q;
  logic            pin_s;
  logic            clr;
  logic            sample;
  logic [NUM_BOARDS-1:0] hit;

  // Two-flop synchronizer for the asynchronous mux output.
  always_ff @(posedge clk) begin
    if (!aresetn) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], sense_pin};
  end

  assign pin_s = sync_q[1];

  // Filters are held clear whenever the block is not actively scanning, and
  // a sample landing on the same edge as an enable drop is discarded.
  assign clr    = (state == IDLE) || !shutdown_sense_en;
  assign sample = (state == SAMPLE) && shutdown_sense_en;
  assign hit    = sample ? (NUM_BOARDS'(1) << sense_sel) : '0;

  // Next-state, shared timer and mux select; enable drop overrides everything.
  always_comb begin
    state_n = state;
    timer_n = timer;
    sel_n   = sense_sel;
    case (state)
      IDLE: begin
        timer_n = '0;
        sel_n   = '0;
        if (shutdown_sense_en) state_n = ARM_WAIT;
      end
      ARM_WAIT: begin
        if (timer == 32'(ARM_DELAY - 1)) begin
          timer_n = '0;
          sel_n   = '0;
          state_n = SETTLE;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      SETTLE: begin
        if (timer == 32'(SETTLE_CYCLES - 1)) begin
          timer_n = '0;
          state_n = SAMPLE;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      SAMPLE: begin
        sel_n   = sense_sel + 3'd1;
        timer_n = '0;
        state_n = SETTLE;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        sel_n   = '0;
      end
    endcase
    if (!shutdown_sense_en && state != IDLE) begin
      state_n = IDLE;
      timer_n = '0;
      sel_n   = '0;
    end
  end

  // State, timer, select and armed flag registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state       <= IDLE;
      timer       <= '0;
      sense_sel   <= '0;
      sense_armed <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      sense_sel   <= sel_n;
      sense_armed <= (state_n == SETTLE) || (state_n == SAMPLE);
    end
  end

  // One filter per board; only the currently selected board sees the sample strobe.
  for (genvar k = 0; k < NUM_BOARDS; k++) begin : g_board
    shutdown_sense_filter #(
      .FILTER_COUNT (FILTER_COUNT),
      .CW           (CW)
    ) u_filt (
      .clk     (clk),
      .aresetn (aresetn),
      .clr     (clr),
      .sample  (hit[k]),
      .pin     (pin_s),
      .flag    (shutdown_sense[k])
    );
  end

endmodule

// File: tb/tb_shutdown_sense_scan.sv
// Bench for shutdown_sense_scan: table of stimulus segments with end-of-segment
// expectations, plus a per-cycle comparison against a timeline model that
// derives the scan position from elapsed cycles since enable.
module tb_shutdown_sense_scan;

  localparam int SC   = 4;
  localparam int FC   = 3;
  localparam int AD   = 10;
  localparam int SLOT = SC + 1;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       shutdown_sense_en;
  logic       sense_pin;
  logic [2:0] sense_sel;
  logic [7:0] shutdown_sense;
  logic       sense_armed;

  shutdown_sense_scan #(
    .SETTLE_CYCLES (SC),
    .FILTER_COUNT  (FC),
    .ARM_DELAY     (AD)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .shutdown_sense_en (shutdown_sense_en),
    .sense_pin         (sense_pin),
    .sense_sel         (sense_sel),
    .shutdown_sense    (shutdown_sense),
    .sense_armed       (sense_armed)
  );

  always #5 clk = ~clk;

  // pmode: 0 pin low, 1 pin high, 2 high only for board 5,
  //        3 board-2 visit pattern 1,1,0,1,1, 4 random pin with rare enable drops
  typedef struct {
    string      nm;
    int         cyc;
    bit         rst_n;
    bit         en;
    int         pmode;
    bit         chk;
    logic [7:0] e_sense;
    logic [2:0] e_sel;
    bit         e_armed;
  } seg_t;

  seg_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Model: n = cycles since enable was first sampled (0 = idle).
  int         n;
  int         run [8];
  logic [7:0] lat;
  bit         p1, p2;
  int         g2;
  logic [4:0] gpat;

  function automatic logic [2:0] m_sel();
    if (n <= AD) return 3'd0;
    return 3'(((n - AD - 1) / SLOT) % 8);
  endfunction

  function automatic bit m_armed();
    return n > AD;
  endfunction

  task automatic model_edge(input bit rst_n, input bit en, input bit pin);
    bit used;
    int m, b;
    used = p2;
    if (!rst_n) begin
      n = 0; lat = '0; p1 = 0; p2 = 0;
      for (int i = 0; i < 8; i++) run[i] = 0;
    end else begin
      p2 = p1;
      p1 = pin;
      if (!en) begin
        n = 0; lat = '0;
        for (int i = 0; i < 8; i++) run[i] = 0;
      end else if (n == 0) begin
        n = 1;
      end else begin
        if (n > AD) begin
          m = n - AD - 1;
          if (m % SLOT == SLOT - 1) begin
            b = (m / SLOT) % 8;
            if (used) begin
              run[b] = (run[b] < FC) ? run[b] + 1 : FC;
              if (run[b] == FC) lat[b] = 1'b1;
            end else begin
              run[b] = 0;
            end
            if (b == 2) g2++;
          end
        end
        n++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got sense=%h sel=%0d armed=%b, want sense=%h sel=%0d armed=%b",
                  nm, act[11:4], act[3:1], act[0], exp[11:4], exp[3:1], exp[0]);
  endtask

  task automatic add(input string nm, input int cyc, input bit rst_n, input bit en,
                     input int pmode, input bit c, input logic [7:0] es,
                     input logic [2:0] esel, input bit ea);
    seg_t s;
    s.nm = nm; s.cyc = cyc; s.rst_n = rst_n; s.en = en; s.pmode = pmode;
    s.chk = c; s.e_sense = es; s.e_sel = esel; s.e_armed = ea;
    tbl.push_back(s);
  endtask

  initial begin
    bit pn, ev;
    aresetn = 1'b0; shutdown_sense_en = 1'b0; sense_pin = 1'b0;
    n = 0; lat = '0; p1 = 0; p2 = 0; g2 = 0; gpat = 5'b11011;
    for (int i = 0; i < 8; i++) run[i] = 0;

    add("reset",        5,    0, 0, 1, 1, 8'h00, 3'd0, 0);
    add("idle_pin_hi",  200,  1, 0, 1, 1, 8'h00, 3'd0, 0);
    add("arm_wait",     10,   1, 1, 0, 1, 8'h00, 3'd0, 0);
    add("arm_rise",     1,    1, 1, 0, 1, 8'h00, 3'd0, 1);
    add("cadence",      40,   1, 1, 0, 1, 8'h00, 3'd0, 1);
    add("b5_pre_latch", 109,  1, 1, 2, 1, 8'h00, 3'd5, 1);
    add("b5_latch",     1,    1, 1, 2, 1, 8'h20, 3'd6, 1);
    add("b5_hold",      80,   1, 1, 0, 1, 8'h20, 3'd6, 1);
    add("b2_glitch",    185,  1, 1, 3, 1, 8'h20, 3'd3, 1);
    add("drop_en",      1,    1, 0, 1, 1, 8'h00, 3'd0, 0);
    add("rearm_all",    11,   1, 1, 1, 1, 8'h00, 3'd0, 1);
    add("all_pre",      119,  1, 1, 1, 1, 8'h7f, 3'd7, 1);
    add("all_latch",    1,    1, 1, 1, 1, 8'hff, 3'd0, 1);
    add("to_sample",    14,   1, 1, 1, 1, 8'hff, 3'd2, 1);
    add("abort_sample", 1,    1, 0, 1, 1, 8'h00, 3'd0, 0);
    add("rearm_wait",   10,   1, 1, 1, 1, 8'h00, 3'd0, 0);
    add("rearm_rise",   1,    1, 1, 1, 1, 8'h00, 3'd0, 1);
    add("clear",        1,    1, 0, 1, 1, 8'h00, 3'd0, 0);
    add("mid_arm",      5,    1, 1, 1, 1, 8'h00, 3'd0, 0);
    add("rst_arm",      1,    0, 1, 1, 1, 8'h00, 3'd0, 0);
    add("scan_partial", 111,  1, 1, 1, 1, 8'h0f, 3'd4, 1);
    add("rst_scan",     1,    0, 1, 1, 1, 8'h00, 3'd0, 0);
    add("post_rst",     3,    1, 0, 1, 1, 8'h00, 3'd0, 0);
    add("random",       3000, 1, 1, 4, 0, 8'h00, 3'd0, 0);
    add("final_drop",   1,    1, 0, 0, 1, 8'h00, 3'd0, 0);

    foreach (tbl[s]) begin
      if (tbl[s].pmode == 3) g2 = 0;
      for (int c = 0; c < tbl[s].cyc; c++) begin
        ev = tbl[s].en;
        case (tbl[s].pmode)
          0:       pn = 1'b0;
          1:       pn = 1'b1;
          2:       pn = (m_sel() == 3'd5);
          3:       pn = (m_sel() == 3'd2) && (g2 < 5) ? gpat[g2] : 1'b0;
          default: begin
            pn = 1'($urandom_range(0, 1));
            ev = tbl[s].en && ($urandom_range(0, 49) != 0);
          end
        endcase
        aresetn = tbl[s].rst_n; shutdown_sense_en = ev; sense_pin = pn;
        @(posedge clk);
        model_edge(tbl[s].rst_n, ev, pn);
        @(negedge clk);
        chk($sformatf("%s.c%0d", tbl[s].nm, c), {shutdown_sense, sense_sel, sense_armed},
            {lat, m_sel(), m_armed()});
      end
      if (tbl[s].chk)
        chk({tbl[s].nm, ".end"}, {shutdown_sense, sense_sel, sense_armed},
            {tbl[s].e_sense, tbl[s].e_sel, tbl[s].e_armed});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
